// File: rtl/tdm_demux.sv
// Receive side of the serial TDM link: hunts for a sync-marked frame start,
// deserializes N_CH*W data bits plus an even-parity bit, and flags parity/sync errors.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  input  logic                in_valid,
  input  logic                in_sync,
  output logic [N_CH*W-1:0]   out_data,
  output logic                out_valid,
  output logic                parity_err,
  output logic                sync_err
);

  localparam int F  = N_CH * W;
  localparam int CW = $clog2(F + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   count_r, count_s;
  logic [F-1:0]    sr_r, sr_s;
  logic [F-1:0]    start_s;
  logic            par_r, par_s;
  logic [F-1:0]    out_data_s;
  logic            out_valid_s, parity_err_s, sync_err_s;

  // The shift register holds bit 0 of the frame in its MSB, so channel 0
  // sits in the top W bits; swap channel order into the output layout.
  function automatic logic [F-1:0] reorder(input logic [F-1:0] sr);
    logic [F-1:0] res;
    res = '0;
    for (int k = 0; k < N_CH; k++) begin
      res[k*W +: W] = sr[(N_CH-1-k)*W +: W];
    end
    return res;
  endfunction

  function automatic logic parity_fail(input logic running, input logic pbit);
    return running ^ pbit;
  endfunction

  // Next-state, datapath and output-pulse logic
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    sr_s         = sr_r;
    par_s        = par_r;
    out_data_s   = out_data;
    out_valid_s  = 1'b0;
    parity_err_s = 1'b0;
    sync_err_s   = 1'b0;
    start_s      = '0;
    start_s[0]   = in_bit;
    if (in_valid) begin
      if (in_sync) begin
        // A sync always starts a fresh frame; outside HUNT it also aborts one.
        sync_err_s = (state_r != HUNT);
        sr_s       = start_s;
        count_s    = CW'(1);
        par_s      = in_bit;
        state_s    = (F == 32'd1) ? PARITY : DATA;
      end else begin
        case (state_r)
          HUNT: begin
            state_s = HUNT;
          end
          DATA: begin
            sr_s    = (sr_r << 1'b1) | start_s;
            count_s = count_r + CW'(1);
            par_s   = par_r ^ in_bit;
            if (count_s == CW'(F)) begin
              state_s = PARITY;
            end else begin
              state_s = DATA;
            end
          end
          PARITY: begin
            out_data_s   = reorder(sr_r);
            out_valid_s  = 1'b1;
            parity_err_s = parity_fail(par_r, in_bit);
            count_s      = '0;
            state_s      = HUNT;
          end
          default: begin
            count_s = '0;
            state_s = HUNT;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= HUNT;
      count_r    <= '0;
      sr_r       <= '0;
      par_r      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      sr_r       <= sr_s;
      par_r      <= par_s;
      out_data   <= out_data_s;
      out_valid  <= out_valid_s;
      parity_err <= parity_err_s;
      sync_err   <= sync_err_s;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: one 4x8 instance and one 1x1 instance share
// the same serial stream; a frame-level model predicts every output event.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_bit = 1'b0, in_valid = 1'b0, in_sync = 1'b0;
  logic [31:0] out_data0;
  logic        out_valid0, parity_err0, sync_err0;
  logic        out_data1;
  logic        out_valid1, parity_err1, sync_err1;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sync(in_sync),
    .out_data(out_data0), .out_valid(out_valid0), .parity_err(parity_err0), .sync_err(sync_err0));

  tdm_demux #(.N_CH(1), .W(1)) dut1 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sync(in_sync),
    .out_data(out_data1), .out_valid(out_valid1), .parity_err(parity_err1), .sync_err(sync_err1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        kind;   // 0: frame output, 1: sync error
    logic [31:0] data;
    logic        perr;
  } ev_t;

  ev_t         q0[$], q1[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  bit          in_frame[2];
  int          nb[2];
  logic [31:0] acc[2];
  bit          par[2];
  logic [31:0] held[2];
  logic [31:0] last_data[2];
  logic        last_perr[2];
  int          nvalid[2], nsync[2];
  int          vcyc_prev = 0, vcyc_last = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse seen but no event expected", name);
  endtask

  task automatic push(input int m, input ev_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Frame-level model: a sync opens a frame (aborting any open one), the next
  // F beats are data in channel order MSB-first, the following beat is parity.
  task automatic model_beat(input int m, input bit b, input bit s);
    int  f, w, idx;
    ev_t e;
    f = (m == 0) ? 32 : 1;
    w = (m == 0) ? 8 : 1;
    if (s) begin
      if (in_frame[m]) begin
        e.kind = 1'b1; e.data = 32'd0; e.perr = 1'b0;
        push(m, e);
      end
      in_frame[m] = 1'b1; nb[m] = 0; acc[m] = 32'd0; par[m] = 1'b0;
    end
    if (in_frame[m]) begin
      if (nb[m] < f) begin
        idx = (nb[m] / w) * w + w - 1 - (nb[m] % w);
        acc[m][idx] = b;
        par[m] = par[m] ^ b;
        nb[m]++;
      end else begin
        e.kind = 1'b0; e.data = acc[m]; e.perr = par[m] ^ b;
        push(m, e);
        in_frame[m] = 1'b0;
      end
    end
  endtask

  task automatic mon(input int m, input logic [31:0] od, input logic ov,
                     input logic pe, input logic se);
    ev_t e;
    int  sz;
    if (se) begin
      nsync[m]++;
      sz = (m == 0) ? q0.size() : q1.size();
      if (sz == 0) flag($sformatf("sync_err%0d", m));
      else begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sync_err%0d event kind", m), {31'd0, se}, {31'd0, e.kind});
      end
    end
    if (ov) begin
      nvalid[m]++;
      sz = (m == 0) ? q0.size() : q1.size();
      if (sz == 0) flag($sformatf("out_valid%0d", m));
      else begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("out_valid%0d event kind", m), {31'd0, ~ov}, {31'd0, e.kind});
        chk($sformatf("out_data%0d", m), od, e.data);
        chk($sformatf("parity_err%0d", m), {31'd0, pe}, {31'd0, e.perr});
        held[m] = e.data; last_data[m] = od; last_perr[m] = pe;
        if (m == 0) begin vcyc_prev = vcyc_last; vcyc_last = cyc; end
      end
    end else begin
      chk($sformatf("out_data%0d hold", m), od, held[m]);
      chk($sformatf("parity_err%0d without valid", m), {31'd0, pe}, 32'd0);
    end
  endtask

  // Monitor: sample outputs mid-cycle and retire scoreboard events
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, out_data0, out_valid0, parity_err0, sync_err0);
      mon(1, {31'd0, out_data1}, out_valid1, parity_err1, sync_err1);
    end
  end

  task automatic beat(input bit b, input bit s);
    @(posedge clk); #1;
    in_bit = b; in_sync = s; in_valid = 1'b1;
    model_beat(0, b, s);
    model_beat(1, b, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sync = $urandom_range(0, 1); in_bit = $urandom_range(0, 1);
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input bit pbit, input int gapmax);
    for (int i = 0; i < 33; i++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      if (i < 32) beat(v[(i / 8) * 8 + 7 - (i % 8)], i == 0);
      else        beat(pbit, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    q0.delete(); q1.delete();
    for (int m = 0; m < 2; m++) begin in_frame[m] = 1'b0; nb[m] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_data0", out_data0, 32'd0);
    chk("reset pulses0", {29'd0, out_valid0, parity_err0, sync_err0}, 32'd0);
    chk("reset dut1", {28'd0, out_data1, out_valid1, parity_err1, sync_err1}, 32'd0);
    held[0] = 32'd0; held[1] = 32'd0;
    rst = 1'b0;
  endtask

  initial begin
    int          sv, ss, r;
    logic [31:0] a, b;
    for (int m = 0; m < 2; m++) begin
      held[m] = 32'd0; nvalid[m] = 0; nsync[m] = 0; last_data[m] = 32'd0; last_perr[m] = 1'b0;
    end
    do_reset();

    // idle with in_sync toggling
    idle(40);
    chk("idle valid count", nvalid[0] + nvalid[1], 32'd0);
    chk("idle sync count", nsync[0] + nsync[1], 32'd0);

    // clean frame, good parity
    sv = nvalid[0];
    send_frame(32'h01FF3CA5, 1'b1, 0); idle(3);
    chk("clean count", nvalid[0] - sv, 32'd1);
    chk("clean data", last_data[0], 32'h01FF3CA5);
    chk("clean perr", {31'd0, last_perr[0]}, 32'd0);

    // same frame, bad parity
    sv = nvalid[0];
    send_frame(32'h01FF3CA5, 1'b0, 0); idle(3);
    chk("badpar count", nvalid[0] - sv, 32'd1);
    chk("badpar data", last_data[0], 32'h01FF3CA5);
    chk("badpar perr", {31'd0, last_perr[0]}, 32'd1);

    // garbage in HUNT, then frame with random gaps
    sv = nvalid[0];
    for (int i = 0; i < 6; i++) beat($urandom_range(0, 1), 1'b0);
    send_frame(32'h01FF3CA5, 1'b1, 3); idle(3);
    chk("gaps count", nvalid[0] - sv, 32'd1);
    chk("gaps data", last_data[0], 32'h01FF3CA5);
    chk("gaps perr", {31'd0, last_perr[0]}, 32'd0);

    // early sync at beat 12, new frame follows from it
    do_reset();
    sv = nvalid[0]; ss = nsync[0];
    for (int i = 0; i < 12; i++) beat($urandom_range(0, 1), i == 0);
    idle(2);
    chk("early sync no valid", nvalid[0] - sv, 32'd0);
    chk("early out_data", out_data0, 32'd0);
    a = 32'h0F0F55AA;
    send_frame(a, ^a, 0); idle(3);
    chk("early sync count", nsync[0] - ss, 32'd1);
    chk("early follow count", nvalid[0] - sv, 32'd1);
    chk("early follow data", last_data[0], a);

    // back-to-back frames
    sv = nvalid[0];
    a = $urandom; b = $urandom;
    send_frame(a, ^a, 0); send_frame(b, ^b, 0); idle(3);
    chk("b2b count", nvalid[0] - sv, 32'd2);
    chk("b2b spacing", vcyc_last - vcyc_prev, 32'd33);
    chk("b2b data", last_data[0], b);

    // reset mid-frame at beat 20
    for (int i = 0; i < 20; i++) beat($urandom_range(0, 1), i == 0);
    idle(1);
    do_reset();
    sv = nvalid[0]; ss = nsync[0];
    send_frame(32'h12345678, ^32'h12345678, 0); idle(3);
    chk("post-rst count", nvalid[0] - sv, 32'd1);
    chk("post-rst data", last_data[0], 32'h12345678);
    chk("post-rst perr", {31'd0, last_perr[0]}, 32'd0);
    chk("post-rst sync", nsync[0] - ss, 32'd0);

    // randomized mix of frames, aborts, garbage and idles
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: begin a = $urandom; send_frame(a, $urandom_range(0, 1), $urandom_range(0, 2)); end
        1: begin
          ss = $urandom_range(1, 33);
          for (int i = 0; i < ss; i++) beat($urandom_range(0, 1), i == 0);
        end
        2: for (int i = 0; i < 4; i++) beat($urandom_range(0, 1), $urandom_range(0, 3) == 0);
        default: idle($urandom_range(1, 5));
      endcase
    end
    idle(3);

    // single-bit frames on the 1x1 instance: data = first bit, perr = xor of both
    do_reset();
    for (int t = 0; t < 4; t++) begin
      bit b0, b1;
      b0 = t[1]; b1 = t[0];
      sv = nvalid[1];
      beat(b0, 1'b1); beat(b1, 1'b0); idle(2);
      chk("1x1 count", nvalid[1] - sv, 32'd1);
      chk("1x1 data", last_data[1], {31'd0, b0});
      chk("1x1 perr", {31'd0, last_perr[1]}, {31'd0, b0 ^ b1});
    end
    sv = nvalid[1];
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b1); beat(1'b1, 1'b0); idle(3);
    chk("1x1 b2b count", nvalid[1] - sv, 32'd2);
    chk("1x1 b2b perr", {31'd0, last_perr[1]}, 32'd1);

    idle(5);
    chk("q0 drained", q0.size(), 32'd0);
    chk("q1 drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
